matrix_result_serializer: RTL and testbench

Downstream stage of the matrix multiplier. It captures the full parallel result matrix `c_o[]` in the cycle the multiplier's `valid_o` is high, then streams the elements out one per handshake, in row-major order, over a valid/ready interface with row/column tags and a last flag. A result that arrives while the previous one is still streaming, and cannot be accepted, is dropped and flagged with a sticky overflow.

---
 rtl/matrix_pkg.sv | 28 ++
 rtl/matrix_index_counter.sv | 58 +++++
 rtl/matrix_result_serializer.sv | 122 ++++++++++++
 tb/tb_matrix_result_serializer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// ============================================================================
// Module      : matrix_pkg
// Description : Shared dimension defaults and width helpers for the matrix
//               multiplier datapath and its downstream stages.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package matrix_pkg;

    localparam int DATA_WIDTH_DEF       = 8;
    localparam int A_ROWS_DEF           = 8;
    localparam int B_COLUMNS_DEF        = 5;
    localparam int A_COLUMNS_B_ROWS_DEF = 4;

    // Index width that never collapses to zero bits (a 1-entry range still needs a wire).
    function automatic int clog2_min1(input int value);
        return ($clog2(value) < 1) ? 1 : $clog2(value);
    endfunction

    // Width of a dot-product result: a full product plus growth for the accumulation.
    function automatic int result_width(input int data_width, input int inner_dim);
        return 2 * data_width + clog2_min1(inner_dim);
    endfunction

endpackage

`default_nettype wire

// File: rtl/matrix_index_counter.sv
// ============================================================================
// Module      : matrix_index_counter
// Description : Row-major (row, col) walker with column wrap into the next row.
//               Clear has priority over advance.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_index_counter
    import matrix_pkg::*;
#(
    parameter int ROWS  = A_ROWS_DEF,
    parameter int COLS  = B_COLUMNS_DEF,
    parameter int ROW_W = clog2_min1(ROWS),
    parameter int COL_W = clog2_min1(COLS)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             advance_i,
    output logic [ROW_W-1:0] row_o,
    output logic [COL_W-1:0] col_o,
    output logic             last_o
);

    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic             w_col_end;
    logic             w_row_end;

    assign w_col_end = (r_col == COL_W'(COLS - 1));
    assign w_row_end = (r_row == ROW_W'(ROWS - 1));

    // Step through the matrix; the final position wraps back to the origin.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_row <= '0;
            r_col <= '0;
        end else if (clear_i) begin
            r_row <= '0;
            r_col <= '0;
        end else if (advance_i) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= w_row_end ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign row_o  = r_row;
    assign col_o  = r_col;
    assign last_o = w_row_end && w_col_end;

endmodule

`default_nettype wire

// File: rtl/matrix_result_serializer.sv
// ============================================================================
// Module      : matrix_result_serializer
// Description : Captures a parallel result matrix and streams its elements in
//               row-major order over valid/ready with row/col tags and last.
//               Results arriving while busy are dropped (sticky overflow).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_result_serializer
    import matrix_pkg::*;
#(
    parameter int DATA_WIDTH = result_width(DATA_WIDTH_DEF, A_COLUMNS_B_ROWS_DEF),
    parameter int A_ROWS     = A_ROWS_DEF,
    parameter int B_COLUMNS  = B_COLUMNS_DEF,
    parameter int ROW_W      = clog2_min1(A_ROWS),
    parameter int COL_W      = clog2_min1(B_COLUMNS)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] c_i [0:A_ROWS*B_COLUMNS-1],
    output logic                  ready_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [ROW_W-1:0]      row_o,
    output logic [COL_W-1:0]      col_o,
    output logic                  last_o,
    output logic                  overflow_o
);

    localparam int N = A_ROWS * B_COLUMNS;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_buf [0:N-1];
    logic                  r_overflow;

    logic                  w_handshake;
    logic                  w_final_hs;
    logic                  w_capture;
    logic                  w_cnt_last;

    assign valid_o     = (r_state == S_STREAM);
    assign w_handshake = valid_o && ready_i;
    assign w_final_hs  = w_handshake && w_cnt_last;
    // The buffer frees up in the same cycle its last element is taken.
    assign ready_o     = (r_state == S_IDLE) || w_final_hs;
    assign w_capture   = valid_i && ready_o;

    // Counter rewinds on a fresh capture or once the stream completes, so an idle
    // block always reports position (0, 0).
    matrix_index_counter #(
        .ROWS  (A_ROWS),
        .COLS  (B_COLUMNS),
        .ROW_W (ROW_W),
        .COL_W (COL_W)
    ) u_index (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clear_i   (w_capture || w_final_hs),
        .advance_i (w_handshake && !w_cnt_last),
        .row_o     (row_o),
        .col_o     (col_o),
        .last_o    (w_cnt_last)
    );

    // Sequencing: a capture always (re)starts the stream, otherwise the final handshake ends it.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else if (w_capture) begin
            r_state <= S_STREAM;
        end else if (w_final_hs) begin
            r_state <= S_IDLE;
        end
    end

    // Result buffer: whole matrix loads only when the block is able to accept it.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int k = 0; k < N; k++) begin
                r_buf[k] <= '0;
            end
        end else if (w_capture) begin
            for (int k = 0; k < N; k++) begin
                r_buf[k] <= c_i[k];
            end
        end
    end

    // Sticky drop flag; only reset clears it.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_overflow <= 1'b0;
        end else if (valid_i && !ready_o) begin
            r_overflow <= 1'b1;
        end
    end

    generate
        if (N == 1) begin : g_single
            assign data_o = r_buf[0];
        end else begin : g_multi
            localparam int IDX_W = clog2_min1(N);
            logic [IDX_W-1:0] w_idx;
            assign w_idx  = IDX_W'(row_o) * IDX_W'(B_COLUMNS) + IDX_W'(col_o);
            assign data_o = r_buf[w_idx];
        end
    endgenerate

    assign last_o     = valid_o && w_cnt_last;
    assign overflow_o = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_matrix_result_serializer.sv
// ============================================================================
// Module      : tb_matrix_result_serializer
// Description : Directed, table-driven bench for matrix_result_serializer
//               (8x5 default instance plus a 1x1 degenerate instance).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_matrix_result_serializer;

    localparam int DW = 18;
    localparam int NE = 40;

    typedef struct {
        logic [DW-1:0] data;
        logic [2:0]    row;
        logic [2:0]    col;
        logic          last;
    } vec_t;

    logic          clk;
    logic          reset_i;
    logic          valid_i;
    logic [DW-1:0] c_in [0:NE-1];
    logic          ready_o;
    logic          valid_o;
    logic          ready_i;
    logic [DW-1:0] data_o;
    logic [2:0]    row_o;
    logic [2:0]    col_o;
    logic          last_o;
    logic          overflow_o;

    logic          valid1_i;
    logic [DW-1:0] c1_in [0:0];
    logic          ready1_o;
    logic          valid1_o;
    logic          ready1_i;
    logic [DW-1:0] data1_o;
    logic [0:0]    row1_o;
    logic [0:0]    col1_o;
    logic          last1_o;
    logic          overflow1_o;

    int   total;
    int   bad;
    vec_t tbl [0:NE-1];

    matrix_result_serializer u_dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .valid_i    (valid_i),
        .c_i        (c_in),
        .ready_o    (ready_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .data_o     (data_o),
        .row_o      (row_o),
        .col_o      (col_o),
        .last_o     (last_o),
        .overflow_o (overflow_o)
    );

    matrix_result_serializer #(
        .DATA_WIDTH (DW),
        .A_ROWS     (1),
        .B_COLUMNS  (1)
    ) u_dut1 (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .valid_i    (valid1_i),
        .c_i        (c1_in),
        .ready_o    (ready1_o),
        .valid_o    (valid1_o),
        .ready_i    (ready1_i),
        .data_o     (data1_o),
        .row_o      (row1_o),
        .col_o      (col1_o),
        .last_o     (last1_o),
        .overflow_o (overflow1_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic load(input int base);
        for (int k = 0; k < NE; k++) begin
            c_in[k] = DW'(base + k);
        end
    endtask

    function automatic logic [25:0] exp_vec(input int k);
        return {1'b1, tbl[k].data, tbl[k].row, tbl[k].col, tbl[k].last};
    endfunction

    function automatic logic [25:0] act_vec();
        return {valid_o, data_o, row_o, col_o, last_o};
    endfunction

    // Drain with ready held high, checking data = base + index; bounded at 100 cycles.
    task automatic drain_check(input int start_idx, input int base, input string name);
        int idx;
        int guard;
        idx   = start_idx;
        guard = 0;
        ready_i = 1'b1;
        while (valid_o && guard < 100) begin
            check(name, 64'(data_o), 64'(base + idx));
            idx++;
            guard++;
            tick();
        end
        check({name, "_count"}, 64'(idx), 64'(NE));
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        clk      = 1'b0;
        reset_i  = 1'b1;
        valid_i  = 1'b0;
        ready_i  = 1'b0;
        valid1_i = 1'b0;
        ready1_i = 1'b0;
        c1_in[0] = '0;
        load(0);

        for (int k = 0; k < NE; k++) begin
            tbl[k].data = DW'(k + 1);
            tbl[k].row  = 3'(k / 5);
            tbl[k].col  = 3'(k % 5);
            tbl[k].last = (k == NE - 1);
        end

        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        tick();

        // Reset state
        check("rst_outputs", {valid_o, last_o, overflow_o, data_o, row_o, col_o},
              {1'b0, 1'b0, 1'b0, 18'd0, 3'd0, 3'd0});
        check("rst_ready", 64'(ready_o), 64'd1);

        // Single result, continuous drain
        load(1);
        valid_i = 1'b1;
        ready_i = 1'b1;
        tick();
        valid_i = 1'b0;
        for (int k = 0; k < NE; k++) begin
            check($sformatf("cont_elem%0d", k), 64'(act_vec()), 64'(exp_vec(k)));
            tick();
        end
        check("cont_end", {valid_o, ready_o}, 2'b01);

        // Backpressure: ready toggles 1/0, element shown in cycle c is (c+1)/2
        load(1);
        valid_i = 1'b1;
        ready_i = 1'b0;
        tick();
        valid_i = 1'b0;
        for (int c = 0; c < 79; c++) begin
            ready_i = (c % 2 == 0);
            check($sformatf("bp_cyc%0d", c), 64'(act_vec()), 64'(exp_vec((c + 1) / 2)));
            tick();
        end
        check("bp_end", {valid_o, ready_o}, 2'b01);

        // Back-to-back capture in the last-handshake cycle
        load(1);
        valid_i = 1'b1;
        ready_i = 1'b1;
        tick();
        valid_i = 1'b0;
        repeat (39) tick();
        check("b2b_last", {valid_o, last_o, data_o}, {1'b1, 1'b1, 18'd40});
        load(100);
        valid_i = 1'b1;
        check("b2b_ready", 64'(ready_o), 64'd1);
        tick();
        valid_i = 1'b0;
        check("b2b_first", 64'(act_vec()), {38'd0, 1'b1, 18'd100, 3'd0, 3'd0, 1'b0});
        check("b2b_ovf", 64'(overflow_o), 64'd0);
        tick();
        drain_check(1, 100, "b2b_drain");
        check("b2b_ovf_end", 64'(overflow_o), 64'd0);

        // Overflow while element 10 is being sent
        load(1);
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        repeat (10) tick();
        check("ovf_elem10", {valid_o, data_o, row_o, col_o}, {1'b1, 18'd11, 3'd2, 3'd0});
        load(500);
        valid_i = 1'b1;
        check("ovf_ready", 64'(ready_o), 64'd0);
        tick();
        valid_i = 1'b0;
        check("ovf_set", 64'(overflow_o), 64'd1);
        drain_check(11, 1, "ovf_drain");
        repeat (3) tick();
        check("ovf_held", {overflow_o, valid_o}, 2'b10);

        // Asynchronous reset during element 20
        load(1000);
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        repeat (20) tick();
        check("arst_elem20", {valid_o, data_o}, {1'b1, 18'd1020});
        #1;
        reset_i = 1'b1;
        #1;
        check("arst_now", {valid_o, ready_o, overflow_o, last_o, data_o},
              {1'b0, 1'b1, 1'b0, 1'b0, 18'd0});
        #1;
        reset_i = 1'b0;
        tick();
        load(300);
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        check("arst_restart", 64'(act_vec()), {38'd0, 1'b1, 18'd300, 3'd0, 3'd0, 1'b0});
        tick();
        drain_check(1, 300, "arst_drain");

        // Degenerate 1x1 instance
        c1_in[0] = 18'h3FFFF;
        valid1_i = 1'b1;
        ready1_i = 1'b1;
        check("n1_ready_idle", 64'(ready1_o), 64'd1);
        tick();
        valid1_i = 1'b0;
        check("n1_elem", {valid1_o, last1_o, data1_o, row1_o, col1_o},
              {1'b1, 1'b1, 18'h3FFFF, 1'b0, 1'b0});
        tick();
        check("n1_done", {valid1_o, ready1_o}, 2'b01);
        // Consecutive results at N=1 stream without a gap
        c1_in[0] = 18'd5;
        valid1_i = 1'b1;
        tick();
        c1_in[0] = 18'd6;
        check("n1_b2b_ready", 64'(ready1_o), 64'd1);
        check("n1_b2b_a", {valid1_o, last1_o, data1_o}, {1'b1, 1'b1, 18'd5});
        tick();
        valid1_i = 1'b0;
        check("n1_b2b_b", {valid1_o, last1_o, data1_o}, {1'b1, 1'b1, 18'd6});
        tick();
        check("n1_b2b_end", {valid1_o, overflow1_o}, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
